// File: rtl/uart_rx_ctrl_if.sv
// Byte-stream and CPU register bus between the UART receiver, the CPU and uart_rx_ctrl.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [1:0]            reg_sel;
  logic                  reg_rd;
  logic                  reg_wr;
  logic [7:0]            reg_wdata;
  logic [31:0]           reg_rdata;

  modport master (
    output s_axis_tdata, s_axis_tvalid, reg_sel, reg_rd, reg_wr, reg_wdata,
    input  s_axis_tready, reg_rdata
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, reg_sel, reg_rd, reg_wr, reg_wdata,
    output s_axis_tready, reg_rdata
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received characters in a FIFO, tracks
// overrun/framing errors and idle timeout, and exposes DATA/STATUS/CTRL/ERRCNT
// registers plus a level interrupt to the CPU.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned CLOCK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned TIMEOUT_CHARS = 4,
  parameter int unsigned IRQ_LEVEL     = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_ctrl_if.slave bus,
  input  logic          rx_busy,
  input  logic          rx_overrun_error,
  input  logic          rx_frame_error,
  output logic          irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  // One character is 10 bit times (start + 8 data + stop).
  localparam longint unsigned T_RAW =
    (64'(TIMEOUT_CHARS) * 64'd10 * 64'(CLOCK_FREQ)) / 64'(BAUD_RATE);
  localparam longint unsigned T_VAL = (T_RAW == 64'd0) ? 64'd1 : T_RAW;
  localparam int unsigned TW = $clog2(T_VAL + 64'd1);
  localparam logic [TW-1:0] T_LIM = TW'(T_VAL);
  localparam logic [TW-1:0] T_PRE = TW'(T_VAL - 64'd1);

  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;
  localparam logic [1:0] SEL_ERRCNT = 2'd3;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  full;
  logic                  empty;

  logic                  enable;
  logic                  irq_en;
  logic                  ovf;
  logic                  frm;
  logic                  timeout;
  logic [7:0]            drop_cnt;
  logic [7:0]            frame_cnt;
  logic [TW-1:0]         t_cnt;

  logic rd_ok, wr_ok, push, flush, pop, admit, accept, drop_full;
  logic tcond, tmo_set, errcnt_wr, status_wr;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum, frame_sum;
  logic [7:0] drop_next, frame_next;

  assign bus.s_axis_tready = ~rst;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Decode the cycle's push/pop/flush events and the error-counter updates.
  always_comb begin
    rd_ok     = bus.reg_rd & ~bus.reg_wr;
    wr_ok     = bus.reg_wr & ~bus.reg_rd;
    push      = bus.s_axis_tvalid & bus.s_axis_tready;
    flush     = wr_ok && (bus.reg_sel == SEL_CTRL) && bus.reg_wdata[2];
    pop       = rd_ok && (bus.reg_sel == SEL_DATA) && !empty;
    admit     = push && enable && !flush;
    // A pop in the same cycle frees the slot the push needs.
    accept    = admit && (!full || pop);
    drop_full = admit && full && !pop;
    status_wr = wr_ok && (bus.reg_sel == SEL_STATUS);
    errcnt_wr = wr_ok && (bus.reg_sel == SEL_ERRCNT);

    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (accept && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !accept) begin
      count_next = count - CW'(1);
    end

    tcond   = !empty && !push && !pop && !rx_busy;
    tmo_set = tcond && (t_cnt == T_PRE);

    drop_inc  = {1'b0, drop_full} + {1'b0, rx_overrun_error};
    drop_sum  = {1'b0, drop_cnt} + 9'(drop_inc);
    frame_sum = {1'b0, frame_cnt} + 9'(rx_frame_error);
    // Clearing write takes priority but still keeps the same-cycle increment.
    if (errcnt_wr) begin
      drop_next  = 8'(drop_inc);
      frame_next = 8'(rx_frame_error);
    end else begin
      drop_next  = drop_sum[8]  ? 8'hFF : drop_sum[7:0];
      frame_next = frame_sum[8] ? 8'hFF : frame_sum[7:0];
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= bus.s_axis_tdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Idle timer: counts quiet cycles with data waiting, holds at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt <= '0;
    end else if (!tcond) begin
      t_cnt <= '0;
    end else if (t_cnt != T_LIM) begin
      t_cnt <= t_cnt + TW'(1);
    end
  end

  // Control bits and sticky status flags; set events win over write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable  <= 1'b1;
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
      frm     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (wr_ok && (bus.reg_sel == SEL_CTRL)) begin
        enable <= bus.reg_wdata[0];
        irq_en <= bus.reg_wdata[1];
      end
      if (drop_full || rx_overrun_error) ovf <= 1'b1;
      else if (status_wr && bus.reg_wdata[4]) ovf <= 1'b0;
      if (rx_frame_error) frm <= 1'b1;
      else if (status_wr && bus.reg_wdata[5]) frm <= 1'b0;
      if (flush || (count_next == '0)) timeout <= 1'b0;
      else if (tmo_set) timeout <= 1'b1;
      else if (status_wr && bus.reg_wdata[6]) timeout <= 1'b0;
    end
  end

  // Saturating error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      drop_cnt  <= drop_next;
      frame_cnt <= frame_next;
    end
  end

  // Registered read data, held until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_rdata <= '0;
    end else if (rd_ok) begin
      case (bus.reg_sel)
        SEL_DATA:   bus.reg_rdata <= empty ? '0 : 32'(mem[rd_ptr]);
        SEL_STATUS: bus.reg_rdata <= {16'd0, 8'(count), 1'b0, timeout, frm, ovf,
                                      irq, full, empty, rx_busy};
        SEL_CTRL:   bus.reg_rdata <= {30'd0, irq_en, enable};
        default:    bus.reg_rdata <= {16'd0, frame_cnt, drop_cnt};
      endcase
    end
  end

  // Level interrupt, registered from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && ((32'(count) >= IRQ_LEVEL) || timeout || ovf || frm);
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver runs a queue-based reference
// model and queues expected read data / irq; a monitor compares them.
module tb_uart_rx_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL   = 4;
  localparam int unsigned TLIM  = 4 * 10 * 1_000_000 / 100_000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0, ovr = 1'b0, ferr = 1'b0;
  logic irq;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_ctrl #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLOCK_FREQ(1_000_000),
    .BAUD_RATE(100_000), .TIMEOUT_CHARS(4), .IRQ_LEVEL(LVL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .rx_busy(busy),
    .rx_overrun_error(ovr), .rx_frame_error(ferr), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd_q[$];
  bit          irq_q[$];

  // Reference model state
  logic [7:0] mq[$];
  bit m_en, m_ien, m_ovf, m_frm, m_tmo, m_irq;
  int m_drop, m_frame, m_idle;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_en = 1; m_ien = 0; m_ovf = 0; m_frm = 0; m_tmo = 0; m_irq = 0;
    m_drop = 0; m_frame = 0; m_idle = 0;
  endfunction

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_step(bit tv, logic [7:0] d, bit rd, bit wr,
                                     logic [1:0] sel, logic [7:0] wd, bit b, bit o, bit f);
    bit rd_ok, wr_ok, flush, pop, drop, tset, cond, irq_next;
    int sz, dinc;
    logic [31:0] r;
    rd_ok = rd && !wr;
    wr_ok = wr && !rd;
    sz    = mq.size();
    flush = wr_ok && sel == 2 && wd[2];
    pop   = rd_ok && sel == 0 && sz > 0;
    drop  = 0;
    tset  = 0;
    if (rd_ok) begin
      case (sel)
        2'd0:    r = (sz > 0) ? {24'd0, mq[0]} : 32'd0;
        2'd1:    r = {16'd0, 8'(sz), 1'b0, m_tmo, m_frm, m_ovf, m_irq,
                      sz == DEPTH, sz == 0, b};
        2'd2:    r = {30'd0, m_ien, m_en};
        default: r = {16'd0, 8'(m_frame), 8'(m_drop)};
      endcase
      rd_q.push_back(r);
    end
    irq_next = m_ien && (sz >= LVL || m_tmo || m_ovf || m_frm);
    irq_q.push_back(irq_next);
    m_irq = irq_next;
    cond = sz > 0 && !tv && !pop && !b;
    if (cond) begin
      if (m_idle < TLIM) begin
        m_idle++;
        tset = (m_idle == TLIM);
      end
    end else begin
      m_idle = 0;
    end
    if (pop) void'(mq.pop_front());
    if (tv && m_en && !flush) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else drop = 1;
    end
    if (flush) mq.delete();
    dinc = int'(drop) + int'(o);
    if (wr_ok && sel == 3) begin
      m_drop = dinc; m_frame = int'(f);
    end else begin
      m_drop = sat(m_drop + dinc); m_frame = sat(m_frame + int'(f));
    end
    if (drop || o) m_ovf = 1;
    else if (wr_ok && sel == 1 && wd[4]) m_ovf = 0;
    if (f) m_frm = 1;
    else if (wr_ok && sel == 1 && wd[5]) m_frm = 0;
    if (flush || mq.size() == 0) m_tmo = 0;
    else if (tset) m_tmo = 1;
    else if (wr_ok && sel == 1 && wd[6]) m_tmo = 0;
    if (wr_ok && sel == 2) begin
      m_en = wd[0]; m_ien = wd[1];
    end
  endfunction

  task automatic cyc(input bit tv, input logic [7:0] td, input bit rd, input bit wr,
                     input logic [1:0] sel, input logic [7:0] wd,
                     input bit b = 0, input bit o = 0, input bit f = 0);
    bus.s_axis_tvalid = tv; bus.s_axis_tdata = td;
    bus.reg_rd = rd; bus.reg_wr = wr; bus.reg_sel = sel; bus.reg_wdata = wd;
    busy = b; ovr = o; ferr = f;
    model_step(tv, td, rd, wr, sel, wd, b, o, f);
    @(posedge clk);
    @(negedge clk);
    bus.s_axis_tvalid = 0; bus.reg_rd = 0; bus.reg_wr = 0;
    busy = 0; ovr = 0; ferr = 0;
  endtask

  task automatic push(input logic [7:0] d);  cyc(1, d, 0, 0, 2'd0, 8'd0); endtask
  task automatic rdreg(input logic [1:0] s); cyc(0, 8'd0, 1, 0, s, 8'd0); endtask
  task automatic wrreg(input logic [1:0] s, input logic [7:0] d); cyc(0, 8'd0, 0, 1, s, d); endtask
  task automatic idle();                     cyc(0, 8'd0, 0, 0, 2'd0, 8'd0); endtask
  task automatic drain();
    while (mq.size() > 0) rdreg(2'd0);
  endtask

  // Monitor: compares irq every driven cycle and read data after each accepted read.
  initial begin
    bit rs;
    forever begin
      @(posedge clk);
      rs = bus.reg_rd && !bus.reg_wr && !rst;
      #1;
      if (!rst) chk("tready", 32'(bus.s_axis_tready), 32'd1);
      if (irq_q.size() > 0) chk("irq", 32'(irq), 32'(irq_q.pop_front()));
      if (rs) begin
        if (rd_q.size() > 0) begin
          chk("reg_rdata", bus.reg_rdata, rd_q.pop_front());
        end else begin
          checks++; failures++;
          $display("FAIL rd_expect actual=read_seen required=queued_expectation");
        end
      end
    end
  end

  initial begin
    bus.s_axis_tvalid = 0; bus.s_axis_tdata = 0;
    bus.reg_rd = 0; bus.reg_wr = 0; bus.reg_sel = 0; bus.reg_wdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.reg_rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    rst = 0;
    @(negedge clk);
    rdreg(2'd1); rdreg(2'd2); rdreg(2'd3);

    // Basic in-order readback, then empty read
    push(8'h41); push(8'h42); push(8'h43);
    rdreg(2'd0); rdreg(2'd0); rdreg(2'd0); rdreg(2'd0); rdreg(2'd1);

    // irq on fill level
    wrreg(2'd2, 8'h03);
    push(8'h01); push(8'h02); push(8'h03); idle(); idle();
    push(8'h04); idle(); idle();
    rdreg(2'd0); idle(); idle();
    drain();
    wrreg(2'd2, 8'h01);

    // Overflow at depth, then W1C of ovf
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    rdreg(2'd1); rdreg(2'd3);
    wrreg(2'd1, 8'h10);
    rdreg(2'd1); rdreg(2'd3);

    // Full FIFO: push alongside DATA read
    cyc(1, 8'h55, 1, 0, 2'd0, 8'd0);
    rdreg(2'd1); rdreg(2'd3);
    drain();
    rdreg(2'd1);

    // Idle timeout, then cleared by emptying read
    push(8'h77);
    repeat (TLIM - 3) idle();
    repeat (4) rdreg(2'd1);
    rdreg(2'd0); rdreg(2'd1);

    // Frame counter saturation and ERRCNT clear
    for (int i = 0; i < 256; i++) cyc(0, 8'd0, 0, 0, 2'd0, 8'd0, 0, 0, 1);
    rdreg(2'd3);
    wrreg(2'd3, 8'h00);
    rdreg(2'd3);
    cyc(0, 8'd0, 0, 1, 2'd3, 8'h00, 0, 1, 1);
    rdreg(2'd3);
    wrreg(2'd1, 8'h70);
    rdreg(2'd1);

    // Flush and rd/wr collision
    push(8'hA0); push(8'hA1);
    cyc(1, 8'hA2, 0, 1, 2'd2, 8'h05);
    rdreg(2'd1);
    push(8'hB0);
    cyc(0, 8'd0, 1, 1, 2'd0, 8'h00);
    rdreg(2'd0); rdreg(2'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit tv, rd, wr, b, o, f;
      logic [1:0] sel;
      logic [7:0] td, wd;
      tv  = ($urandom_range(0, 1) == 1);
      rd  = ($urandom_range(0, 4) == 0);
      wr  = ($urandom_range(0, 15) == 0);
      sel = 2'($urandom_range(0, 3));
      td  = 8'($urandom);
      wd  = 8'($urandom);
      if (wr && sel == 2) wd[0] = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 4) == 0);
      o   = ($urandom_range(0, 31) == 0);
      f   = ($urandom_range(0, 31) == 0);
      cyc(tv, td, rd, wr, sel, wd, b, o, f);
    end
    rdreg(2'd1); rdreg(2'd3);

    // Reset with data buffered
    wrreg(2'd2, 8'h03);
    drain();
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    rst = 1;
    #1;
    chk("midrst_rdata", bus.reg_rdata, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_tready", 32'(bus.s_axis_tready), 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rdreg(2'd1); rdreg(2'd0); rdreg(2'd2); rdreg(2'd3);

    repeat (3) @(negedge clk);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL leftover actual=%0d/%0d required=0/0", rd_q.size(), irq_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
